// File: rtl/sha256_msg_server.sv
// Message-word responder for the SHA-256 stream core. Holds the 80-byte block
// header and a live nonce, and serves the three padded chunks of a double hash.
//
// Handshake: the initiator raises rq with addr/mode and holds it. rdy pulses
// for exactly one cycle with data valid. The server then waits in RELEASE
// until rq is seen low, so a held rq is never acknowledged twice.
module sha256_msg_server #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned NONCE_WORD  = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rq,
  input  logic [3:0]   addr,
  output logic [31:0]  data,
  output logic         rdy,
  input  logic [1:0]   mode,
  input  logic [255:0] digest_in,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         nonce_load,
  input  logic [31:0]  nonce_init,
  input  logic         nonce_inc,
  output logic [31:0]  nonce,
  output logic         nonce_wrap,
  output logic         busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [4:0] NONCE_IDX = 5'(NONCE_WORD);
  localparam logic [4:0] HDR_WORDS = 5'd20;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  addr_q;
  logic [1:0]  mode_q;
  logic        load_data;
  logic [31:0] hw [20];

  logic [3:0]  sel_addr;
  logic [1:0]  sel_mode;
  logic [31:0] word;
  logic [4:0]  hdr_idx;
  logic        use_hdr;
  logic [31:0] dw [8];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load_data = 1'b0;
    case (state)
      S_IDLE: begin
        if (rq) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_ACK;
            load_data = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_ACK;
          load_data = 1'b1;
        end
      end
      S_ACK: state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (!rq) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr_q <= 4'd0;
      mode_q <= 2'd0;
      data   <= 32'd0;
      rdy    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && rq) begin
        addr_q <= addr;
        mode_q <= mode;
        cnt    <= WAIT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (load_data) data <= word;
      rdy <= load_data;
    end
  end

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Word map. With zero wait cycles data is registered on the accepting edge,
  // so the live addr/mode are used there; otherwise the latched copies.
  // ---------------------------------------------------------------------------
  assign sel_addr = (state == S_IDLE) ? addr : addr_q;
  assign sel_mode = (state == S_IDLE) ? mode : mode_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      dw[i] = digest_in[255 - 32*i -: 32];
    end
  end

  always_comb begin
    word    = 32'd0;
    hdr_idx = 5'd0;
    use_hdr = 1'b0;
    case (sel_mode)
      2'd0: begin
        use_hdr = 1'b1;
        hdr_idx = {1'b0, sel_addr};
      end
      2'd1: begin
        if (sel_addr < 4'd4) begin
          use_hdr = 1'b1;
          hdr_idx = 5'd16 + {3'b000, sel_addr[1:0]};
        end else if (sel_addr == 4'd4) begin
          word = 32'h8000_0000;
        end else if (sel_addr == 4'd15) begin
          word = 32'h0000_0280;
        end
      end
      2'd2: begin
        if (sel_addr < 4'd8) begin
          word = dw[sel_addr[2:0]];
        end else if (sel_addr == 4'd8) begin
          word = 32'h8000_0000;
        end else if (sel_addr == 4'd15) begin
          word = 32'h0000_0100;
        end
      end
      default: word = 32'd0;
    endcase
    // The nonce slot is always fed from the live counter, never the stored word.
    if (use_hdr) begin
      word = (hdr_idx == NONCE_IDX) ? nonce : hw[hdr_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Header storage and nonce counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 20; i++) hw[i] <= 32'd0;
    end else if (wr_en && wr_addr < HDR_WORDS) begin
      hw[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nonce      <= 32'd0;
      nonce_wrap <= 1'b0;
    end else if (nonce_load) begin
      nonce      <= nonce_init;
      nonce_wrap <= 1'b0;
    end else if (nonce_inc) begin
      nonce      <= nonce + 32'd1;
      nonce_wrap <= (nonce == 32'hFFFF_FFFF);
    end else begin
      nonce_wrap <= 1'b0;
    end
  end

endmodule
